gmii_rx_framer: RTL and testbench

//  Receive-side MAC framer directly downstream of the GMII PHY interface (8-bit SDR GMII).
//  - Strips preamble/SFD, checks CRC-32 FCS, strips FCS.
//  - Emits each frame as an 8-bit AXI-Stream with a bad-frame flag on the last beat, plus per-frame status pulses.
//  - No backpressure: GMII cannot stall, so there is no m_axis_tready.

---
 rtl/eth_pkg.sv | 37 +++
 rtl/eth_crc32_d8.sv | 21 ++
 rtl/gmii_rx_framer.sv | 209 ++++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants and types for the GMII receive path: framing bytes, CRC-32
// parameters, receive FSM states and the per-frame status vector.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;

    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    localparam int unsigned LEN_W     = 11;
    localparam int unsigned DLY_DEPTH = 5;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        WAIT_END
    } rx_state_t;

    typedef struct packed {
        logic good;
        logic bad_fcs;
        logic bad_frame;
        logic runt;
        logic oversize;
        logic preamble;
    } rx_stat_t;

    // Length counter increment that sticks at the saturation value.
    function automatic logic [LEN_W-1:0] len_inc_sat(input logic [LEN_W-1:0] len,
                                                     input logic [LEN_W-1:0] sat);
        return (len >= sat) ? sat : len + LEN_W'(1);
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32, processing bit 0 of the
// data byte first.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (CRC32_POLY & {32{c[0] ^ d[i]}});
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD and FCS, checks CRC-32 and length,
// and streams payload bytes out as AXI-Stream with per-frame status pulses.
module gmii_rx_framer
    import eth_pkg::*;
#(
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_rx_frame_good,
    output logic       stat_rx_err_bad_fcs,
    output logic       stat_rx_err_bad_frame,
    output logic       stat_rx_err_runt,
    output logic       stat_rx_err_oversize,
    output logic       stat_rx_err_preamble
);

    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_FRAME_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT  = LEN_W'(MAX_FRAME_LEN + 1);
    localparam logic [LEN_W-1:0] DLY_FULL = LEN_W'(DLY_DEPTH);

    logic [7:0]       rxd_q;
    logic             dv_q;
    logic             er_q;

    rx_state_t        state_q, state_d;
    logic [7:0]       dly_q [DLY_DEPTH];
    logic [7:0]       dly_d [DLY_DEPTH];
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      crc_q, crc_d, crc_next;
    logic             er_seen_q, er_seen_d;

    logic [7:0]       tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             tuser_q, tuser_d;
    rx_stat_t         stat_q, stat_d;

    logic [7:0]       oldest;
    logic             start_frame;

    eth_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .d       (rxd_q),
        .crc_out (crc_next)
    );

    // Oldest byte still held: the last payload byte once the line is full,
    // otherwise the first byte of a short frame (0 if nothing arrived).
    always_comb begin
        oldest = 8'h00;
        if (len_q >= DLY_FULL) begin
            oldest = dly_q[DLY_DEPTH-1];
        end else if (len_q != '0) begin
            oldest = dly_q[3'(len_q - LEN_W'(1))];
        end
    end

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        len_d       = len_q;
        crc_d       = crc_q;
        er_seen_d   = er_seen_q;
        tdata_d     = 8'h00;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;
        stat_d      = '0;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                if (dv_q) begin
                    if (rxd_q == ETH_PREAMBLE) begin
                        state_d = PREAMBLE;
                    end else if (rxd_q == ETH_SFD) begin
                        state_d     = PAYLOAD;
                        start_frame = 1'b1;
                    end else begin
                        state_d         = WAIT_END;
                        stat_d.preamble = 1'b1;
                    end
                end
            end

            PREAMBLE: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end else if (er_q) begin
                    state_d = WAIT_END;
                end else if (rxd_q == ETH_SFD) begin
                    state_d     = PAYLOAD;
                    start_frame = 1'b1;
                end else if (rxd_q != ETH_PREAMBLE) begin
                    state_d         = WAIT_END;
                    stat_d.preamble = 1'b1;
                end
            end

            PAYLOAD: begin
                if (!dv_q) begin
                    // End of carrier: the delay line holds the FCS plus the last payload byte.
                    tvalid_d         = 1'b1;
                    tlast_d          = 1'b1;
                    tdata_d          = oldest;
                    stat_d.bad_fcs   = (crc_q != CRC32_RESIDUE);
                    stat_d.runt      = (len_q < MIN_LEN);
                    stat_d.bad_frame = er_seen_q;
                    tuser_d          = stat_d.bad_fcs | stat_d.runt | stat_d.bad_frame;
                    stat_d.good      = !tuser_d;
                    state_d          = IDLE;
                end else begin
                    dly_d[0] = rxd_q;
                    for (int unsigned i = 1; i < DLY_DEPTH; i++) begin
                        dly_d[i] = dly_q[i-1];
                    end
                    crc_d     = crc_next;
                    er_seen_d = er_seen_q | er_q;
                    len_d     = len_inc_sat(len_q, LEN_SAT);
                    if (len_q == MAX_LEN) begin
                        tvalid_d         = 1'b1;
                        tlast_d          = 1'b1;
                        tuser_d          = 1'b1;
                        tdata_d          = oldest;
                        stat_d.oversize  = 1'b1;
                        stat_d.bad_frame = er_seen_q | er_q;
                        state_d          = WAIT_END;
                    end else if (len_q >= DLY_FULL) begin
                        tvalid_d = 1'b1;
                        tdata_d  = oldest;
                    end
                end
            end

            WAIT_END: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            len_d     = '0;
            crc_d     = CRC32_INIT;
            er_seen_d = 1'b0;
            for (int unsigned i = 0; i < DLY_DEPTH; i++) begin
                dly_d[i] = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_q     <= 8'h00;
            dv_q      <= 1'b0;
            er_q      <= 1'b0;
            state_q   <= IDLE;
            for (int unsigned i = 0; i < DLY_DEPTH; i++) begin
                dly_q[i] <= 8'h00;
            end
            len_q     <= '0;
            crc_q     <= CRC32_INIT;
            er_seen_q <= 1'b0;
            tdata_q   <= 8'h00;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            stat_q    <= '0;
        end else begin
            rxd_q     <= gmii_rxd;
            dv_q      <= gmii_rx_dv;
            er_q      <= gmii_rx_er;
            state_q   <= state_d;
            dly_q     <= dly_d;
            len_q     <= len_d;
            crc_q     <= crc_d;
            er_seen_q <= er_seen_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            stat_q    <= stat_d;
        end
    end

    assign m_axis_tdata          = tdata_q;
    assign m_axis_tvalid         = tvalid_q;
    assign m_axis_tlast          = tlast_q;
    assign m_axis_tuser          = tuser_q;
    assign stat_rx_frame_good    = stat_q.good;
    assign stat_rx_err_bad_fcs   = stat_q.bad_fcs;
    assign stat_rx_err_bad_frame = stat_q.bad_frame;
    assign stat_rx_err_runt      = stat_q.runt;
    assign stat_rx_err_oversize  = stat_q.oversize;
    assign stat_rx_err_preamble  = stat_q.preamble;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: a table of frames with expected beat
// counts and status, plus hand-written oversize/IFG and mid-frame reset cases.
module tb_gmii_rx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       stat_rx_frame_good;
    logic       stat_rx_err_bad_fcs;
    logic       stat_rx_err_bad_frame;
    logic       stat_rx_err_runt;
    logic       stat_rx_err_oversize;
    logic       stat_rx_err_preamble;

    gmii_rx_framer dut (
        .clk                   (clk),
        .rst                   (rst),
        .gmii_rxd              (gmii_rxd),
        .gmii_rx_dv            (gmii_rx_dv),
        .gmii_rx_er            (gmii_rx_er),
        .m_axis_tdata          (m_axis_tdata),
        .m_axis_tvalid         (m_axis_tvalid),
        .m_axis_tlast          (m_axis_tlast),
        .m_axis_tuser          (m_axis_tuser),
        .stat_rx_frame_good    (stat_rx_frame_good),
        .stat_rx_err_bad_fcs   (stat_rx_err_bad_fcs),
        .stat_rx_err_bad_frame (stat_rx_err_bad_frame),
        .stat_rx_err_runt      (stat_rx_err_runt),
        .stat_rx_err_oversize  (stat_rx_err_oversize),
        .stat_rx_err_preamble  (stat_rx_err_preamble)
    );

    always #4 clk = ~clk;

    typedef struct {
        string name;
        int    n_data;
        bit    raw;
        bit    flip;
        int    er_pos;
        int    beats;
        int    tuser;
        int    good;
        int    fcs;
        int    frm;
        int    runt;
        int    over;
    } vec_t;

    typedef struct {
        int beats;
        int derr;
        int tuser;
        int good;
        int fcs;
        int frm;
        int runt;
        int over;
    } rec_t;

    int   total = 0;
    int   bad   = 0;
    logic [7:0] tx_buf  [2048];
    logic [7:0] exp_buf [2048];
    int   tx_len;
    rec_t recq[$];
    int   cur_beats = 0;
    int   cur_derr  = 0;
    int   pre_cnt   = 0;
    int   stray     = 0;
    vec_t vecs[7];

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Output monitor: collects beats per frame and snapshots status at tlast.
    always @(negedge clk) begin
        if (rst) begin
            cur_beats = 0;
            cur_derr  = 0;
        end else begin
            if (m_axis_tvalid) begin
                if (cur_beats >= 2048 || m_axis_tdata != exp_buf[cur_beats]) cur_derr++;
                cur_beats++;
                if (m_axis_tlast) begin
                    recq.push_back('{cur_beats, cur_derr, int'(m_axis_tuser),
                                     int'(stat_rx_frame_good), int'(stat_rx_err_bad_fcs),
                                     int'(stat_rx_err_bad_frame), int'(stat_rx_err_runt),
                                     int'(stat_rx_err_oversize)});
                    cur_beats = 0;
                    cur_derr  = 0;
                end
            end
            if (stat_rx_err_preamble) pre_cnt++;
            if (!(m_axis_tvalid && m_axis_tlast) &&
                (stat_rx_frame_good || stat_rx_err_bad_fcs || stat_rx_err_bad_frame ||
                 stat_rx_err_runt || stat_rx_err_oversize)) stray++;
        end
    end

    task automatic build_frame(input int n_data, input bit raw, input bit flip, input int seed);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n_data; i++) begin
            tx_buf[i] = 8'(i * 29 + seed * 13 + 1);
            c = crc_step(c, tx_buf[i]);
        end
        tx_len = n_data;
        if (!raw) begin
            c = ~c;
            if (flip) c[0] = ~c[0];
            for (int k = 0; k < 4; k++) tx_buf[n_data + k] = c[8*k +: 8];
            tx_len = n_data + 4;
        end
    endtask

    task automatic send_pre();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            gmii_rx_dv = 1'b1;
            gmii_rx_er = 1'b0;
            gmii_rxd   = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int j = 0; j < tx_len; j++) exp_buf[j] = tx_buf[j];
    endtask

    task automatic send_frame(input int er_pos, input int ifg);
        send_pre();
        for (int i = 0; i < tx_len; i++) begin
            @(negedge clk);
            gmii_rxd   = tx_buf[i];
            gmii_rx_er = (i == er_pos);
        end
        for (int i = 0; i < ifg; i++) begin
            @(negedge clk);
            gmii_rx_dv = 1'b0;
            gmii_rx_er = 1'b0;
            gmii_rxd   = 8'h00;
        end
    endtask

    task automatic check_rec(input string nm, input int beats, input int tuser, input int good,
                             input int fcs, input int frm, input int runt, input int over);
        rec_t r;
        int   waited;
        waited = 0;
        while (recq.size() == 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (recq.size() == 0) begin
            bad++;
            $display("FAIL %s_tlast: got no tlast beat within 50 cycles want one", nm);
            return;
        end
        r = recq.pop_front();
        chk({nm, "_beats"}, r.beats, beats);
        chk({nm, "_data"}, r.derr, 0);
        chk({nm, "_tuser"}, r.tuser, tuser);
        chk({nm, "_good"}, r.good, good);
        if (fcs >= 0) chk({nm, "_bad_fcs"}, r.fcs, fcs);
        chk({nm, "_bad_frame"}, r.frm, frm);
        chk({nm, "_runt"}, r.runt, runt);
        chk({nm, "_oversize"}, r.over, over);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_tvalid"}, int'(m_axis_tvalid), 0);
        chk({nm, "_tlast"}, int'(m_axis_tlast), 0);
        chk({nm, "_tuser"}, int'(m_axis_tuser), 0);
        chk({nm, "_tdata"}, int'(m_axis_tdata), 0);
        chk({nm, "_stats"}, int'({stat_rx_frame_good, stat_rx_err_bad_fcs, stat_rx_err_bad_frame,
                                  stat_rx_err_runt, stat_rx_err_oversize, stat_rx_err_preamble}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pre0;
        //          name       ndata raw flip er  beats tuser good fcs frm runt over
        vecs[0] = '{"good64",    60, 0, 0,  -1,   60, 0, 1,  0, 0, 0, 0};
        vecs[1] = '{"badfcs",    60, 0, 1,  -1,   60, 1, 0,  1, 0, 0, 0};
        vecs[2] = '{"rxer20",    60, 0, 0,  20,   60, 1, 0,  0, 1, 0, 0};
        vecs[3] = '{"runt40",    36, 0, 0,  -1,   36, 1, 0,  0, 0, 1, 0};
        vecs[4] = '{"short3",     3, 1, 0,  -1,    1, 1, 0, -1, 0, 1, 0};
        vecs[5] = '{"runt63",    59, 0, 0,  -1,   59, 1, 0,  0, 0, 1, 0};
        vecs[6] = '{"max1518", 1514, 0, 0,  -1, 1514, 0, 1,  0, 0, 0, 0};

        rst        = 1'b1;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        foreach (vecs[v]) begin
            build_frame(vecs[v].n_data, vecs[v].raw, vecs[v].flip, v);
            send_frame(vecs[v].er_pos, 12);
            check_rec(vecs[v].name, vecs[v].beats, vecs[v].tuser, vecs[v].good,
                      vecs[v].fcs, vecs[v].frm, vecs[v].runt, vecs[v].over);
        end

        // 2000-byte frame truncated at byte 1519, then a good frame after a 1-cycle gap.
        build_frame(1996, 0, 0, 5);
        send_frame(-1, 1);
        build_frame(60, 0, 0, 7);
        send_frame(-1, 12);
        check_rec("oversize", 1514, 1, 0, -1, 0, 0, 1);
        check_rec("after_oversize", 60, 0, 1, 0, 0, 0, 0);

        // Reset at payload byte 30, carrier stays up with a non-preamble byte.
        build_frame(60, 0, 0, 9);
        send_pre();
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            gmii_rxd = tx_buf[i];
        end
        #2;
        chk("pre_rst_tvalid", int'(m_axis_tvalid), 1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("mid_rst");
        pre0 = pre_cnt;
        @(negedge clk);
        gmii_rxd = 8'h20;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b1;
        @(negedge clk);
        gmii_rx_er = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_no_tlast", recq.size(), 0);
        chk("rst_no_beats", cur_beats, 0);
        chk("rst_preamble_pulse", pre_cnt - pre0, 1);

        build_frame(60, 0, 0, 11);
        send_frame(-1, 12);
        check_rec("post_rst_good", 60, 0, 1, 0, 0, 0, 0);

        chk("stray_stats", stray, 0);
        chk("preamble_total", pre_cnt, 1);
        chk("leftover_frames", recq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
